// File: rtl/fft_frame_loader.sv
// Double-buffered sample collector for the FFT processor: packs a serial sample stream into
// 16-word frames and launches each full bank with a one-cycle new_t pulse gated by fft_done.
module fft_frame_loader #(
    parameter bit BITREV = 1'b0,
    parameter bit SIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    input  logic        fft_done,
    output logic        new_t,
    output logic [15:0] t0,
    output logic [15:0] t1,
    output logic [15:0] t2,
    output logic [15:0] t3,
    output logic [15:0] t4,
    output logic [15:0] t5,
    output logic [15:0] t6,
    output logic [15:0] t7,
    output logic [15:0] t8,
    output logic [15:0] t9,
    output logic [15:0] t10,
    output logic [15:0] t11,
    output logic [15:0] t12,
    output logic [15:0] t13,
    output logic [15:0] t14,
    output logic [15:0] t15,
    output logic [7:0]  frame_count
);

    logic [15:0] r_bank [2][16];
    logic [1:0]  r_full;
    logic [3:0]  r_wr_cnt;
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic        r_new_t;
    logic [7:0]  r_frame_count;

    logic        w_accept;
    logic        w_fill_done;
    logic        w_launch;
    logic [3:0]  w_wr_addr;
    logic [15:0] w_wr_data;
    logic [1:0]  w_full_next;

    // Handshake: a sample moves on a rising edge where sample_valid and sample_ready are both high.
    assign sample_ready = !r_full[r_wr_ptr];
    assign w_accept     = sample_valid && sample_ready;
    assign w_fill_done  = w_accept && (r_wr_cnt == 4'd15);
    assign w_wr_addr    = BITREV ? {r_wr_cnt[0], r_wr_cnt[1], r_wr_cnt[2], r_wr_cnt[3]} : r_wr_cnt;
    assign w_wr_data    = SIGNED ? sample_in : {~sample_in[15], sample_in[14:0]};
    assign w_launch     = r_full[r_rd_ptr] && fft_done && !r_new_t;

    // Fill and capture always target opposite banks, so both updates can land on one edge.
    always_comb begin
        w_full_next = r_full;
        if (r_new_t) w_full_next[r_rd_ptr] = 1'b0;
        if (w_fill_done) w_full_next[r_wr_ptr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < 16; i++) begin
                    r_bank[b][i] <= '0;
                end
            end
        end else if (w_accept) begin
            r_bank[r_wr_ptr][w_wr_addr] <= w_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full        <= '0;
            r_wr_cnt      <= '0;
            r_wr_ptr      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_new_t       <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_full  <= w_full_next;
            r_new_t <= w_launch;
            if (w_accept) begin
                r_wr_cnt <= r_wr_cnt + 4'd1;
                if (r_wr_cnt == 4'd15) r_wr_ptr <= ~r_wr_ptr;
            end
            // The processor loads t0..t15 on the edge that ends the new_t pulse.
            if (r_new_t) begin
                r_rd_ptr      <= ~r_rd_ptr;
                r_frame_count <= r_frame_count + 8'd1;
            end
        end
    end

    assign new_t       = r_new_t;
    assign frame_count = r_frame_count;

    assign t0  = r_bank[r_rd_ptr][0];
    assign t1  = r_bank[r_rd_ptr][1];
    assign t2  = r_bank[r_rd_ptr][2];
    assign t3  = r_bank[r_rd_ptr][3];
    assign t4  = r_bank[r_rd_ptr][4];
    assign t5  = r_bank[r_rd_ptr][5];
    assign t6  = r_bank[r_rd_ptr][6];
    assign t7  = r_bank[r_rd_ptr][7];
    assign t8  = r_bank[r_rd_ptr][8];
    assign t9  = r_bank[r_rd_ptr][9];
    assign t10 = r_bank[r_rd_ptr][10];
    assign t11 = r_bank[r_rd_ptr][11];
    assign t12 = r_bank[r_rd_ptr][12];
    assign t13 = r_bank[r_rd_ptr][13];
    assign t14 = r_bank[r_rd_ptr][14];
    assign t15 = r_bank[r_rd_ptr][15];

endmodule

// File: tb/tb_fft_frame_loader.sv
// Scoreboard bench for fft_frame_loader: three instances (natural, bit-reversed, offset-binary)
// share one stimulus stream; a frame-level model predicts ready, launches and frame contents.
module tb_fft_frame_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        fft_done;
    logic [2:0]  rdy;
    logic [2:0]  nt;
    logic [7:0]  fc [3];
    logic [15:0] tw [3][16];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        fft_frame_loader #(.BITREV(g == 1), .SIGNED(g != 2)) u_dut (
            .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
            .sample_ready(rdy[g]), .fft_done(fft_done), .new_t(nt[g]),
            .t0(tw[g][0]), .t1(tw[g][1]), .t2(tw[g][2]), .t3(tw[g][3]),
            .t4(tw[g][4]), .t5(tw[g][5]), .t6(tw[g][6]), .t7(tw[g][7]),
            .t8(tw[g][8]), .t9(tw[g][9]), .t10(tw[g][10]), .t11(tw[g][11]),
            .t12(tw[g][12]), .t13(tw[g][13]), .t14(tw[g][14]), .t15(tw[g][15]),
            .frame_count(fc[g])
        );
    end

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];
    logic [15:0] exp_q2[$];
    logic [15:0] cur_q[$];
    int          pending = 0;
    int          launches = 0;
    bit          launch_next = 1'b0;
    bit [2:0]    prev_nt = '0;
    int          busy = 0;
    bit          done_en = 1'b1;
    bit          stop_stall = 1'b0;

    assign fft_done = done_en && (busy == 0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] conv(input int g, input logic [15:0] s);
        return (g == 2) ? (s ^ 16'h8000) : s;
    endfunction

    function automatic int place(input int g, input int k);
        if (g != 1) return k;
        return ((k & 1) * 8) + (((k >> 1) & 1) * 4) + (((k >> 2) & 1) * 2) + ((k >> 3) & 1);
    endfunction

    task automatic push_frame();
        logic [15:0] f [16];
        for (int g = 0; g < 3; g++) begin
            for (int k = 0; k < 16; k++) f[place(g, k)] = conv(g, cur_q[k]);
            for (int k = 0; k < 16; k++) begin
                case (g)
                    0: exp_q0.push_back(f[k]);
                    1: exp_q1.push_back(f[k]);
                    default: exp_q2.push_back(f[k]);
                endcase
            end
        end
        cur_q.delete();
    endtask

    task automatic compare_frame(input int g);
        logic [15:0] e;
        int          sz;
        for (int k = 0; k < 16; k++) begin
            sz = (g == 0) ? exp_q0.size() : (g == 1) ? exp_q1.size() : exp_q2.size();
            if (sz == 0) begin
                chk($sformatf("frame_underflow_i%0d", g), 32'd0, 32'd1);
            end else begin
                case (g)
                    0: e = exp_q0.pop_front();
                    1: e = exp_q1.pop_front();
                    default: e = exp_q2.pop_front();
                endcase
                chk($sformatf("t%0d_i%0d", k, g), tw[g][k], e);
            end
        end
    endtask

    // Monitor: everything is judged on the falling edge, i.e. the state seen by the next rising edge.
    always @(negedge clk) begin
        bit exp_nt;
        if (rst_n) begin
            exp_nt = launch_next;
            for (int g = 0; g < 3; g++) begin
                chk($sformatf("ready_i%0d", g), rdy[g], pending < 2);
                chk($sformatf("new_t_i%0d", g), nt[g], exp_nt);
                chk($sformatf("frame_count_i%0d", g), fc[g], launches % 256);
                if (nt[g]) chk($sformatf("new_t_double_i%0d", g), prev_nt[g], 1'b0);
                prev_nt[g] = nt[g];
            end
            if (exp_nt) for (int g = 0; g < 3; g++) compare_frame(g);
            launch_next = (pending > 0) && fft_done && !exp_nt;
            if (sample_valid && pending < 2) begin
                cur_q.push_back(sample_in);
                if (cur_q.size() == 16) begin
                    push_frame();
                    pending++;
                end
            end
            if (exp_nt) begin
                pending--;
                launches++;
            end
        end
    end

    // Engine model: done stays low for three cycles after each capture.
    always @(posedge clk) begin
        bit nt_was;
        nt_was = nt[0];
        #1;
        if (!rst_n) busy = 0;
        else if (nt_was) busy = 3;
        else if (busy > 0) busy--;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [15:0] d);
        bit acc;
        int tries;
        tries = 0;
        sample_valid = 1'b1;
        sample_in    = d;
        do begin
            @(negedge clk);
            acc = rdy[0];
            @(posedge clk);
            #1;
            tries++;
        end while (!acc && tries < 200);
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
        sample_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((pending != 0 || launch_next) && t < 300) begin
            tick(1);
            t++;
        end
        tick(2);
        chk("drain_pending", pending, 0);
    endtask

    task automatic model_reset();
        cur_q.delete();
        exp_q0.delete();
        exp_q1.delete();
        exp_q2.delete();
        pending     = 0;
        launches    = 0;
        launch_next = 1'b0;
        prev_nt     = '0;
        busy        = 0;
    endtask

    task automatic reset_checks();
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("rst_new_t_i%0d", g), nt[g], 1'b0);
            chk($sformatf("rst_ready_i%0d", g), rdy[g], 1'b1);
            chk($sformatf("rst_frame_count_i%0d", g), fc[g], 8'd0);
            for (int k = 0; k < 16; k++) chk($sformatf("rst_t%0d_i%0d", k, g), tw[g][k], 16'h0000);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        reset_checks();
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        do_reset();

        // Natural and bit-reversed ordering of a counting frame.
        for (int i = 0; i < 16; i++) send(16'(i));
        drain();
        chk("t1_frame_count", fc[0], 8'd1);

        // Offset-binary corner values.
        send(16'h8000);
        send(16'h0000);
        send(16'hFFFF);
        for (int i = 3; i < 16; i++) send(16'($urandom));
        drain();

        // Engine stalled: both banks fill, ready drops, then two spaced launches.
        do_reset();
        done_en = 1'b0;
        fork
            for (int i = 0; i < 40; i++) send(16'(i));
            begin
                tick(60);
                chk("t3_no_launch_while_stalled", launches, 0);
                done_en = 1'b1;
            end
        join
        drain();
        chk("t3_frame_count", fc[0], 8'd2);

        // Reset in the middle of a frame.
        for (int i = 0; i < 7; i++) send(16'($urandom));
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        reset_checks();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 100; i < 116; i++) send(16'(i));
        drain();

        // Random valid gaps and random done stalls.
        stop_stall = 1'b0;
        fork
            begin
                for (int i = 0; i < 64; i++) begin
                    if ($urandom_range(0, 1) == 1) tick($urandom_range(1, 3));
                    send(16'($urandom));
                end
                stop_stall = 1'b1;
            end
            while (!stop_stall) begin
                tick(1);
                if ($urandom_range(0, 15) == 0) begin
                    done_en = 1'b0;
                    tick($urandom_range(5, 30));
                end
                done_en = ($urandom_range(0, 3) != 0);
            end
        join
        done_en = 1'b1;
        drain();

        // Long back-to-back run so frame_count wraps.
        for (int i = 0; i < 260 * 16; i++) send(16'($urandom));
        drain();
        chk("wrap_frame_count", fc[0], 32'(launches % 256));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
